regfile_dump: RTL and testbench

Sequential read-out engine for the 32×32 register file. On a start pulse it walks read port 0 from address 0 to NREGS-1 and streams each register as an (address, data) beat over a valid/ready interface. The stream feeds the debug/display path. It is the reader that pairs with the register file's write port: it drives `ra`, samples `rd` and never writes.

---
 rtl/regdump_pkg.sv | 22 ++
 rtl/regfile_dump.sv | 156 +++++++++++++++
 tb/tb_regfile_dump.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
// Shared types for the register-file dump engine: FSM encoding and default widths.
// Latency: n/a (package only).
// Backpressure: n/a. The CSUM state exists only when REGDUMP_CHECKSUM_EN is defined.
package regdump_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/regfile_dump.sv
// Streams registers 0..NREGS-1 of a register file as (addr, data) beats over valid/ready.
// Latency: first beat one cycle after start; one beat per cycle while out_ready is high.
// Backpressure: beats are held stable while out_ready is low. REGDUMP_CHECKSUM_EN adds an XOR checksum beat.
module regfile_dump
  import regdump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_csum,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              hs;
  logic              at_last;

  // ptr is the address of the next register to fetch; it is 0 whenever idle
  assign ra      = ptr;
  assign hs      = out_valid && out_ready;
  assign at_last = (out_addr == LAST_ADDR);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: abort wins over start and over a same-cycle handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !abort) state_nxt = SEND;
      SEND: begin
        if (abort) state_nxt = IDLE;
        else if (hs && at_last) begin
`ifdef REGDUMP_CHECKSUM_EN
          state_nxt = CSUM;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: if (abort || hs) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake-side outputs decoded from the current state and beat registers
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    out_csum  = 1'b0;
    case (state)
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
`ifndef REGDUMP_CHECKSUM_EN
        out_last  = at_last;
`endif
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = 1'b1;
        out_csum  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  // Running XOR of every register beat accepted in the current dump
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (state == IDLE && start && !abort) begin
      csum <= '0;
    end else if (state == SEND && hs && !abort) begin
      csum <= csum ^ out_data;
    end
  end
`endif

  // Beat registers, fetch pointer and done pulse; rd is sampled on the cycle a beat is loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      out_addr <= '0;
      out_data <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            out_data <= rd;
            out_addr <= ptr;
            ptr      <= ptr + ADDR_W'(1);
          end
        end
        SEND: begin
          if (abort) begin
            ptr <= '0;
          end else if (hs) begin
            if (at_last) begin
              ptr <= '0;
`ifdef REGDUMP_CHECKSUM_EN
              out_addr <= '0;
              out_data <= csum ^ out_data;
`else
              done     <= 1'b1;
`endif
            end else begin
              out_data <= rd;
              out_addr <= ptr;
              ptr      <= ptr + ADDR_W'(1);
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CSUM: begin
          ptr <= '0;
          if (!abort && hs) done <= 1'b1;
        end
`endif
        default: ptr <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural 32x32 register file (comb read, clocked write).
// Also exercises the checksum beat when built with REGDUMP_CHECKSUM_EN.
module tb_regfile_dump;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_csum;
  logic          busy;
  logic          done;

  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic [DW-1:0] mem [NR];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd = mem[ra];

  always @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  regfile_dump #(.ADDR_W(AW), .DATA_W(DW), .NREGS(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ra(ra), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .out_last(out_last), .out_csum(out_csum),
    .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic write_reg(input int a, input logic [DW-1:0] v);
    we = 1'b1; wa = AW'(a); wd = v;
    step();
    we = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input int idx, input logic [DW-1:0] d);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_addr"},  64'(out_addr), 64'(idx));
    check({tag, "_data"},  64'(out_data), 64'(d));
`ifdef REGDUMP_CHECKSUM_EN
    check({tag, "_last"},  64'(out_last), 64'd0);
`else
    check({tag, "_last"},  64'(out_last), 64'(idx == NR - 1));
`endif
    check({tag, "_csum"},  64'(out_csum), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd1);
  endtask

  // Entered at the sample point after the final register handshake
  task automatic finish_dump(input string tag, input logic [DW-1:0] exp_csum);
`ifdef REGDUMP_CHECKSUM_EN
    check({tag, "_cs_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_cs_flag"},  64'(out_csum), 64'd1);
    check({tag, "_cs_last"},  64'(out_last), 64'd1);
    check({tag, "_cs_addr"},  64'(out_addr), 64'd0);
    check({tag, "_cs_data"},  64'(out_data), 64'(exp_csum));
    check({tag, "_cs_done"},  64'(done), 64'd0);
    step();
`else
    check({tag, "_no_csum"},  64'(out_csum), 64'(exp_csum & 32'h0));
`endif
    check({tag, "_done"},  64'(done), 64'd1);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_ra"},    64'(ra), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] x;
    logic [DW-1:0] d;
    int            exp_i;
    int            cyc;

    // Reset state, observed while rst is asserted
    #2;
    check("rst_ra",    64'(ra), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr",  64'(out_addr), 64'd0);
    check("rst_data",  64'(out_data), 64'd0);
    check("rst_last",  64'(out_last), 64'd0);
    check("rst_csum",  64'(out_csum), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    #1 rst = 1'b0;
    step();

    for (int i = 0; i < NR; i++) write_reg(i, DW'(i * 3));

    // Full dump with out_ready held high, then restart in the done cycle
    check("t1_idle_ra", 64'(ra), 64'd0);
    start = 1'b1; step(); start = 1'b0;
    x = '0;
    for (int i = 0; i < NR; i++) begin
      expect_beat("t1", i, DW'(i * 3));
      x ^= DW'(i * 3);
      step();
    end
    finish_dump("t1", x);
    start = 1'b1; step(); start = 1'b0;
    expect_beat("t1_restart", 0, '0);
    abort = 1'b1; step(); abort = 1'b0;
    check("t1_abort_valid", 64'(out_valid), 64'd0);
    check("t1_abort_done",  64'(done), 64'd0);

    // out_ready toggling 1,0,0,...: beats hold while stalled, order preserved
    start = 1'b1; step(); start = 1'b0;
    exp_i = 0; cyc = 0; x = '0;
    while (exp_i < NR && cyc < 300) begin
      out_ready = (cyc % 3 == 0);
      expect_beat("t2", exp_i, DW'(exp_i * 3));
      if (out_ready) begin
        x ^= DW'(exp_i * 3);
        exp_i++;
      end
      step();
      cyc++;
    end
    check("t2_all_beats", 64'(exp_i), 64'(NR));
    out_ready = 1'b1;
    finish_dump("t2", x);
    step();

    // Write to a not-yet-fetched register is visible
    start = 1'b1; step(); start = 1'b0;
    x = '0;
    for (int i = 0; i < NR; i++) begin
      d = (i == 5) ? 32'hDEADBEEF : DW'(i * 3);
      expect_beat("t3a", i, d);
      x ^= d;
      if (i == 0) begin we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; end
      step();
      we = 1'b0;
    end
    finish_dump("t3a", x);
    write_reg(5, 32'd15);

    // Write landing on the same edge that loads beat 5: old value streams
    start = 1'b1; step(); start = 1'b0;
    x = '0;
    for (int i = 0; i < NR; i++) begin
      expect_beat("t3b", i, DW'(i * 3));
      x ^= DW'(i * 3);
      if (i == 4) begin we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; end
      step();
      we = 1'b0;
    end
    finish_dump("t3b", x);
    write_reg(5, 32'd15);

    // Abort at beat 10 together with a handshake
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      expect_beat("t4", i, DW'(i * 3));
      if (i == 10) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    check("t4_valid", 64'(out_valid), 64'd0);
    check("t4_busy",  64'(busy), 64'd0);
    check("t4_done",  64'(done), 64'd0);
    check("t4_ra",    64'(ra), 64'd0);
    step();
    check("t4_done_late", 64'(done), 64'd0);

    // Abort beats start in idle
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    check("t4_abort_idle", 64'(out_valid), 64'd0);

    // Restart from 0, start held mid-dump is ignored, async reset at beat 20
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      expect_beat("t5", i, DW'(i * 3));
      start = (i >= 2 && i <= 4);
      if (i < 20) step();
    end
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ra",    64'(ra), 64'd0);
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_addr",  64'(out_addr), 64'd0);
    check("t5_rst_data",  64'(out_data), 64'd0);
    check("t5_rst_last",  64'(out_last), 64'd0);
    check("t5_rst_busy",  64'(busy), 64'd0);
    check("t5_rst_done",  64'(done), 64'd0);
    #2 rst = 1'b0;
    step();
    check("t5_post_valid", 64'(out_valid), 64'd0);
    check("t5_post_done",  64'(done), 64'd0);

`ifdef REGDUMP_CHECKSUM_EN
    // reg[i]=i: checksum is XOR 0..31 = 0
    for (int i = 0; i < NR; i++) write_reg(i, DW'(i));
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < NR; i++) begin
      expect_beat("t6a", i, DW'(i));
      step();
    end
    finish_dump("t6a", 32'h0);

    // Single non-zero register: checksum equals it
    for (int i = 0; i < NR; i++) write_reg(i, (i == 7) ? 32'hA5 : 32'h0);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < NR; i++) begin
      expect_beat("t6b", i, (i == 7) ? 32'hA5 : 32'h0);
      step();
    end
    finish_dump("t6b", 32'hA5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
